dec8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 3-to-8 binary decoder output port among eight requesters. It registers an index and an enable, which drive the decoder's `a[2:0]` and `en` inputs. It also provides the matching registered one-hot grant, so the decoder and arbiter outputs are identical whenever the grant is valid. The block sits directly in front of the decoder and holds each grant until the owner releases it or a programmable hold limit expires.

---
 rtl/dec8_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_dec8_rr_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dec8_rr_arbiter.sv
// Round-robin arbiter in front of a 3-to-8 decoder.
// It registers the decoder select (a) and enable (en), plus a matching one-hot grant.
// Each grant is held until the owner releases it (done, or its req bit drops).
// A grant is also force-released after MAX_HOLD cycles; MAX_HOLD = 0 disables that limit.
// Every release passes through one idle cycle, so the decoder always goes through all-zero.
//
// state | meaning
// IDLE  | no grant; arbitration runs each cycle starting after 'last'
// GRANT | one owner drives the decoder; the hold counter is running
module dec8_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       en,
    output logic [2:0] a,
    output logic [7:0] gnt,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit         LIMIT_ON  = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = LIMIT_ON ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     state, state_nxt;
    logic       en_nxt;
    logic [2:0] a_nxt;
    logic [7:0] gnt_nxt;
    logic       timeout_nxt;
    logic [2:0] last, last_nxt;
    logic [7:0] hold_cnt, hold_nxt;

    logic [2:0] cand;
    logic [2:0] win_idx;
    logic       win_found;

    // Round-robin search: last+1 .. last+8 (mod 8); the first set request wins.
    // The previous owner therefore has the lowest priority.
    always_comb begin
        cand      = last;
        win_idx   = last;
        win_found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cand = last + i[2:0];
            if (!win_found && req[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; all outputs are registered from these values.
    always_comb begin
        state_nxt   = state;
        en_nxt      = en;
        a_nxt       = a;
        gnt_nxt     = gnt;
        timeout_nxt = 1'b0;
        last_nxt    = last;
        hold_nxt    = hold_cnt;
        case (state)
            IDLE: begin
                en_nxt   = 1'b0;
                gnt_nxt  = 8'h00;
                hold_nxt = 8'd0;
                if (win_found) begin
                    state_nxt = GRANT;
                    en_nxt    = 1'b1;
                    a_nxt     = win_idx;
                    last_nxt  = win_idx;
                    gnt_nxt   = 8'b1 << win_idx;
                end
            end
            GRANT: begin
                // A normal release takes priority over the hold limit, so timeout stays low.
                if (done || !req[a]) begin
                    state_nxt = IDLE;
                    en_nxt    = 1'b0;
                    gnt_nxt   = 8'h00;
                    hold_nxt  = 8'd0;
                end else if (LIMIT_ON && (hold_cnt == HOLD_LAST)) begin
                    state_nxt   = IDLE;
                    en_nxt      = 1'b0;
                    gnt_nxt     = 8'h00;
                    hold_nxt    = 8'd0;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
                gnt_nxt   = 8'h00;
                hold_nxt  = 8'd0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously; last = 7 so the first search starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            en       <= 1'b0;
            a        <= 3'd0;
            gnt      <= 8'h00;
            timeout  <= 1'b0;
            last     <= 3'd7;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            en       <= en_nxt;
            a        <= a_nxt;
            gnt      <= gnt_nxt;
            timeout  <= timeout_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_dec8_rr_arbiter.sv
// Directed bench for dec8_rr_arbiter with MAX_HOLD = 4.
module tb_dec8_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       en;
    logic [2:0] a;
    logic [7:0] gnt;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic       en;
        logic [2:0] a;
        logic [7:0] gnt;
        logic       to;
    } vec_t;

    vec_t vecs[$];

    dec8_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .en      (en),
        .a       (a),
        .gnt     (gnt),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic e_en, input logic [2:0] e_a,
                             input logic [7:0] e_gnt, input logic e_to);
        check({name, ".en"}, {7'd0, en}, {7'd0, e_en});
        check({name, ".a"}, {5'd0, a}, {5'd0, e_a});
        check({name, ".gnt"}, gnt, e_gnt);
        check({name, ".timeout"}, {7'd0, timeout}, {7'd0, e_to});
    endtask

    // Drive inputs, let one rising edge pass, then compare 1 ns later.
    task automatic step(input string name, input logic [7:0] r, input logic d, input logic e_en,
                        input logic [2:0] e_a, input logic [7:0] e_gnt, input logic e_to);
        req  = r;
        done = d;
        @(posedge clk);
        #1;
        check_all(name, e_en, e_a, e_gnt, e_to);
    endtask

    function automatic void add(input logic [7:0] r, input logic d, input logic e_en,
                                input logic [2:0] e_a, input logic [7:0] e_gnt, input logic e_to);
        vec_t v;
        v.req  = r;
        v.done = d;
        v.en   = e_en;
        v.a    = e_a;
        v.gnt  = e_gnt;
        v.to   = e_to;
        vecs.push_back(v);
    endfunction

    initial begin
        // Round robin: owner 0 is already granted; release, then grant 1..7, then 0 again.
        add(8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        add(8'hFF, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        add(8'hFF, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
        add(8'hFF, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0);
        add(8'hFF, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
        add(8'hFF, 1'b0, 1'b1, 3'd3, 8'h08, 1'b0);
        add(8'hFF, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
        add(8'hFF, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0);
        add(8'hFF, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
        add(8'hFF, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0);
        add(8'hFF, 1'b1, 1'b0, 3'd5, 8'h00, 1'b0);
        add(8'hFF, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0);
        add(8'hFF, 1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
        add(8'hFF, 1'b0, 1'b1, 3'd7, 8'h80, 1'b0);
        add(8'hFF, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0);
        add(8'hFF, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        add(8'hFF, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        // Wrap and skip: owner 6 releases with req = 0000_0101 -> 0, 2, 0.
        add(8'h40, 1'b0, 1'b1, 3'd6, 8'h40, 1'b0);
        add(8'h05, 1'b1, 1'b0, 3'd6, 8'h00, 1'b0);
        add(8'h05, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        add(8'h05, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        add(8'h05, 1'b0, 1'b1, 3'd2, 8'h04, 1'b0);
        add(8'h05, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0);
        add(8'h05, 1'b0, 1'b1, 3'd0, 8'h01, 1'b0);
        add(8'h05, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
        // Request drop: owner 4 loses req[4]; a holds 4 while idle; done in IDLE is ignored.
        add(8'h10, 1'b0, 1'b1, 3'd4, 8'h10, 1'b0);
        add(8'h00, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0);
        add(8'h00, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
        // Hold limit 4: four cycles with en high, a timeout pulse, then a regrant.
        add(8'h02, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        add(8'h02, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        add(8'h02, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        add(8'h02, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        add(8'h02, 1'b0, 1'b0, 3'd1, 8'h00, 1'b1);
        add(8'h02, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        // Same again, with done on cycle 4: the normal release wins and there is no timeout.
        add(8'h02, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        add(8'h02, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        add(8'h02, 1'b0, 1'b1, 3'd1, 8'h02, 1'b0);
        add(8'h02, 1'b1, 1'b0, 3'd1, 8'h00, 1'b0);
        add(8'h00, 1'b0, 1'b0, 3'd1, 8'h00, 1'b0);

        // Reset held with all requests set.
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);

        // Release reset with only requester 3 active.
        req = 8'h08;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("first_grant", 1'b1, 3'd3, 8'h08, 1'b0);
        step("release3", 8'h08, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
        step("grant5", 8'h20, 1'b0, 1'b1, 3'd5, 8'h20, 1'b0);

        // Asynchronous reset mid-grant: outputs clear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_all("async_reset", 1'b0, 3'd0, 8'h00, 1'b0);
        req = 8'hFF;
        #2 rst_n = 1'b1;
        // With last back at 7, the first search after reset picks index 0.
        @(posedge clk);
        #1;
        check_all("post_reset_grant", 1'b1, 3'd0, 8'h01, 1'b0);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].done, vecs[i].en,
                 vecs[i].a, vecs[i].gnt, vecs[i].to);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
